// File: rtl/risky_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : risky_fetch_if
//  Description : Bus bundle for the risky_fetch stage: instruction-memory
//                request/response, execute redirect and the decode handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
interface risky_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    // Fetch-stage side
    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, if_ready
    );

    // Environment side (memory, execute, decode)
    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, if_ready
    );
endinterface
`default_nettype wire

// File: rtl/risky_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : risky_fetch
//  Description : Instruction-fetch stage. Owns the PC, issues word fetches
//                under a credit limit, buffers responses in a small FIFO with
//                a registered head and drops fetches made stale by redirects.
//  Revision    : 1.0 - initial release
// ============================================================================
module risky_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    risky_fetch_if.master bus
);

    localparam int c_CW = $clog2(DEPTH + 1);
    localparam logic [c_CW:0] c_DEPTH = (c_CW + 1)'(DEPTH);

    typedef logic [c_CW-1:0] cnt_t;

    logic [31:0]             r_fetch_pc;
    cnt_t                    r_inflight;
    cnt_t                    r_discard;
    cnt_t                    r_count;
    logic [DEPTH-1:0][31:0]  r_tag;       // PCs of in-flight requests, oldest in [0]
    logic [DEPTH-1:0][63:0]  r_fifo;      // {pc, instr}, head in [0]

    logic [c_CW:0]           w_occupancy;
    logic                    w_req_valid;
    logic                    w_accept;
    logic                    w_resp;
    logic                    w_keep;
    logic                    w_pop;
    cnt_t                    w_tag_wr;
    cnt_t                    w_fifo_wr;
    logic [DEPTH-1:0][31:0]  w_tag_shift;
    logic [DEPTH-1:0][63:0]  w_fifo_shift;
    logic                    w_unused_pc_lsb;

    // Credits: every in-flight fetch (stale or not) and every buffered entry
    // holds one slot, so a returning response always finds FIFO space.
    assign w_occupancy = {1'b0, r_inflight} + {1'b0, r_count};
    // Gated by rst_n so no request leaves while reset is held.
    assign w_req_valid = rst_n && !bus.redirect_valid && (w_occupancy < c_DEPTH);
    assign w_accept    = w_req_valid && bus.imem_req_ready;
    // A response with nothing in flight is a stray (e.g. from before reset).
    assign w_resp      = bus.imem_resp_valid && (r_inflight != '0);
    assign w_keep      = w_resp && (r_discard == '0) && !bus.redirect_valid;
    assign w_pop       = (r_count != '0) && bus.if_ready;

    // Write slots account for the entry leaving the queue in the same cycle.
    assign w_tag_wr     = r_inflight - cnt_t'(w_resp);
    assign w_fifo_wr    = r_count - cnt_t'(w_pop);
    assign w_tag_shift  = r_tag >> 32;
    assign w_fifo_shift = r_fifo >> 64;

    assign w_unused_pc_lsb = ^bus.redirect_pc[1:0];

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_fetch_pc;
    assign bus.if_valid       = (r_count != '0);
    assign bus.if_pc          = r_fifo[0][63:32];
    assign bus.if_instr       = r_fifo[0][31:0];

    // Fetch PC: redirect target (word aligned) wins over sequential advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= {RESET_PC[31:2], 2'b00};
        end else if (bus.redirect_valid) begin
            r_fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
        end else if (w_accept) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
        end
    end

    // In-flight count and the number of in-flight responses to throw away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
            r_discard  <= '0;
        end else begin
            r_inflight <= r_inflight + cnt_t'(w_accept) - cnt_t'(w_resp);
            if (bus.redirect_valid) begin
                r_discard <= r_inflight - cnt_t'(w_resp);
            end else if (w_resp && (r_discard != '0)) begin
                r_discard <= r_discard - cnt_t'(1);
            end
        end
    end

    // PC tag queue: push on accept, pop on every counted response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_accept && (w_tag_wr == cnt_t'(i))) begin
                    r_tag[i] <= r_fetch_pc;
                end else if (w_resp) begin
                    r_tag[i] <= w_tag_shift[i];
                end
            end
        end
    end

    // Instruction FIFO: head register drives decode directly; redirect flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo  <= '0;
            r_count <= '0;
        end else begin
            if (bus.redirect_valid) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + cnt_t'(w_keep) - cnt_t'(w_pop);
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (w_keep && (w_fifo_wr == cnt_t'(i))) begin
                    r_fifo[i] <= {r_tag[0], bus.imem_resp_data};
                end else if (w_pop) begin
                    r_fifo[i] <= w_fifo_shift[i];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_risky_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_risky_fetch
//  Description : Self-checking bench for risky_fetch. A queue-based model of
//                outstanding fetches and buffered instructions predicts the
//                outputs every cycle; directed scenarios pin literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_risky_fetch;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    risky_fetch_if bus();

    risky_fetch #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    typedef struct {logic [31:0] pc; bit stale;} pend_t;
    typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
    typedef struct {logic [31:0] addr; int due;} mreq_t;

    // Model state
    pend_t       q_pend[$];   // accepted fetches awaiting a response
    ent_t        q_out[$];    // instructions decode should see, in order
    logic [31:0] m_pc;
    // Environment state
    mreq_t       mem_q[$];
    logic [31:0] log_pc[$];
    logic [31:0] log_in[$];
    logic [31:0] acc_log[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int lat = 1, ready_mode = 0, rr_mode = 0, resp_mode = 0, redir_pct = 0;
    bit force_redir = 0;
    logic [31:0] force_pc = '0;
    bit redir_on_addr_en = 0;
    logic [31:0] redir_on_addr = '0, redir_on_pc = '0;
    bit trig = 0;
    logic trig_req = 1'b0;
    bit stray = 0;
    logic cap_req_valid, cap_if_valid;
    logic [31:0] cap_addr, cap_if_pc, cap_if_instr;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h0001_0001) ^ 32'hC0DE_0013;
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int idx);
        return (idx < q.size()) ? q[idx] : 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_idle();
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.if_ready        = 1'b0;
    endtask

    task automatic model_clear();
        q_pend.delete();
        q_out.delete();
        mem_q.delete();
        m_pc = 32'h0;
    endtask

    // One clock cycle; entered and left at a falling edge.
    task automatic step();
        bit          b_if_ready, b_req_ready, rv, from_mem, rd, exp_req, pop;
        logic [31:0] data, rpc;
        pend_t       p;
        b_if_ready  = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'b0 : 1'($urandom_range(1));
        b_req_ready = (rr_mode == 0) ? 1'b1 : ($urandom_range(3) != 0);
        rv = 0; from_mem = 0; data = $urandom;
        if (stray) begin
            rv = 1; data = 32'hBAD0_0000 | cyc; stray = 0;
        end else if (mem_q.size() > 0 && mem_q[0].due <= cyc &&
                     (resp_mode == 0 || $urandom_range(2) != 0)) begin
            rv = 1; from_mem = 1; data = mem_data(mem_q[0].addr);
        end
        rd  = force_redir || (redir_pct > 0 && $urandom_range(99) < redir_pct);
        rpc = force_redir ? force_pc : $urandom;
        force_redir = 0;
        if (redir_on_addr_en && from_mem && mem_q[0].addr == redir_on_addr) begin
            rd = 1; rpc = redir_on_pc; trig = 1; redir_on_addr_en = 0;
        end
        bus.if_ready        = b_if_ready;
        bus.imem_req_ready  = b_req_ready;
        bus.imem_resp_valid = rv;
        bus.imem_resp_data  = data;
        bus.redirect_valid  = rd;
        bus.redirect_pc     = rpc;
        #1;
        exp_req = !rd && (q_pend.size() + q_out.size() < DEPTH);
        chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
        chk("req_addr", bus.imem_req_addr, m_pc);
        chk("if_valid", 32'(bus.if_valid), 32'(q_out.size() != 0));
        if (q_out.size() != 0) begin
            chk("if_pc", bus.if_pc, q_out[0].pc);
            chk("if_instr", bus.if_instr, q_out[0].instr);
        end
        cap_req_valid = bus.imem_req_valid;
        cap_addr      = bus.imem_req_addr;
        cap_if_valid  = bus.if_valid;
        cap_if_pc     = bus.if_pc;
        cap_if_instr  = bus.if_instr;
        if (trig && rd && rpc == redir_on_pc) trig_req = bus.imem_req_valid;
        @(posedge clk);
        if (from_mem) void'(mem_q.pop_front());
        if (cap_req_valid && b_req_ready) begin
            mem_q.push_back('{addr: cap_addr, due: cyc + lat});
            acc_log.push_back(cap_addr);
        end
        if (cap_if_valid && b_if_ready) begin
            log_pc.push_back(cap_if_pc);
            log_in.push_back(cap_if_instr);
        end
        // Model: consume, then fill, then apply redirect effects.
        pop = (q_out.size() > 0) && b_if_ready;
        if (pop) void'(q_out.pop_front());
        if (rv && q_pend.size() > 0) begin
            p = q_pend.pop_front();
            if (!p.stale && !rd) q_out.push_back('{pc: p.pc, instr: data});
        end
        if (rd) begin
            q_out.delete();
            foreach (q_pend[i]) q_pend[i].stale = 1'b1;
            m_pc = {rpc[31:2], 2'b00};
        end else if (exp_req && b_req_ready) begin
            q_pend.push_back('{pc: m_pc, stale: 1'b0});
            m_pc = m_pc + 32'd4;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        model_clear();
        acc_log.delete(); log_pc.delete(); log_in.delete();
        ready_mode = 0; rr_mode = 0; resp_mode = 0; redir_pct = 0; lat = 1;
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_if_valid"}, 32'(bus.if_valid), 32'h0);
        chk({tag, "_if_pc"}, bus.if_pc, 32'h0);
        chk({tag, "_if_instr"}, bus.if_instr, 32'h0);
        chk({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'h0);
        chk({tag, "_req_addr"}, bus.imem_req_addr, 32'h0);
    endtask

    initial begin
        int n;
        bit found;
        rst_n = 1'b0;
        drive_idle();
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        do_reset();

        // Latency 1, decode always ready
        repeat (12) step();
        chk("first_acc", qget(acc_log, 0), 32'h0);
        chk("seq_pc0", qget(log_pc, 0), 32'h0);
        chk("seq_pc1", qget(log_pc, 1), 32'h4);
        chk("seq_pc2", qget(log_pc, 2), 32'h8);
        chk("seq_in0", qget(log_in, 0), 32'hC0DE_0013);
        chk("seq_in1", qget(log_in, 1), 32'hC0DA_0017);

        // Decode stalls for 5 cycles after the first instruction appears
        do_reset();
        ready_mode = 1;
        for (int i = 0; i < 10 && q_out.size() == 0; i++) step();
        repeat (5) step();
        chk("stall_req_dropped", 32'(cap_req_valid), 32'h0);
        chk("stall_hold_pc", cap_if_pc, 32'h0);
        ready_mode = 0;
        log_pc.delete();
        repeat (10) step();
        chk("stall_pc0", qget(log_pc, 0), 32'h0);
        chk("stall_pc1", qget(log_pc, 1), 32'h4);
        chk("stall_pc2", qget(log_pc, 2), 32'h8);

        // Latency 3: redirect with two fetches in flight
        do_reset();
        lat = 3;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (q_pend.size() == 2 && q_out.size() == 0) found = 1;
        end
        chk("two_inflight", 32'(found), 32'h1);
        log_pc.delete();
        force_redir = 1; force_pc = 32'h100;
        repeat (16) step();
        chk("redir_first_pc", qget(log_pc, 0), 32'h100);
        n = 0;
        foreach (log_pc[i]) if (log_pc[i] < 32'h100) n++;
        chk("redir_no_stale", n, 0);

        // Redirect in the same cycle as the response for PC 0x4
        do_reset();
        lat = 2; trig = 0; trig_req = 1'b1;
        redir_on_addr_en = 1; redir_on_addr = 32'h4; redir_on_pc = 32'h200;
        for (int i = 0; i < 20 && !trig; i++) step();
        redir_on_addr_en = 0;
        chk("resp_redir_hit", 32'(trig), 32'h1);
        chk("resp_redir_no_req", 32'(trig_req), 32'h0);
        log_pc.delete();
        repeat (12) step();
        chk("resp_redir_pc", qget(log_pc, 0), 32'h200);
        n = 0;
        foreach (log_pc[i]) if (log_pc[i] == 32'h4) n++;
        chk("resp_redir_no_4", n, 0);

        // Redirect alignment and PC wrap
        do_reset();
        repeat (3) step();
        acc_log.delete();
        force_redir = 1; force_pc = 32'h203;
        repeat (6) step();
        chk("align_acc0", qget(acc_log, 0), 32'h200);
        chk("align_acc1", qget(acc_log, 1), 32'h204);
        acc_log.delete();
        force_redir = 1; force_pc = 32'hFFFF_FFFC;
        repeat (6) step();
        chk("wrap_acc0", qget(acc_log, 0), 32'hFFFF_FFFC);
        chk("wrap_acc1", qget(acc_log, 1), 32'h0);

        // Asynchronous reset with a full FIFO, then stray responses
        do_reset();
        ready_mode = 1;
        repeat (6) step();
        chk("full_before_reset", q_out.size(), DEPTH);
        drive_idle();
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("async_reset");
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'hBAD0_BAD0;
        repeat (2) @(negedge clk);
        model_clear();
        acc_log.delete(); log_pc.delete(); log_in.delete();
        ready_mode = 0;
        rst_n = 1'b1;
        stray = 1;
        repeat (10) step();
        chk("post_reset_acc0", qget(acc_log, 0), 32'h0);
        chk("post_reset_pc0", qget(log_pc, 0), 32'h0);
        chk("post_reset_in0", qget(log_in, 0), 32'hC0DE_0013);

        // Randomized traffic across latencies
        for (int r = 0; r < 4; r++) begin
            lat = 1 + r; rr_mode = 1; resp_mode = 1; ready_mode = 2; redir_pct = 6;
            repeat (300) step();
        end
        rr_mode = 0; resp_mode = 0; ready_mode = 0; redir_pct = 0;
        repeat (30) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
